// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers (ID/EX, EX/MEM, MEM/WB).
// Control-bit layout and the default-width ID/EX payload live here.
package pipe_pkg;

    localparam int CTRL_W        = 5;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_WDC      = 3;
    localparam int CTRL_CBWRITE  = 2;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_MEMREAD  = 0;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_IMM_W    = 5;
    localparam int DEF_ALUCTL_W = 4;

    typedef struct packed {
        logic [DEF_ALUCTL_W-1:0] alucontrol;
        logic [CTRL_W-1:0]       ctrl;
        logic [DEF_DATA_W-1:0]   rs_data;
        logic [DEF_DATA_W-1:0]   rt_data;
        logic [DEF_ADDR_W-1:0]   rs_addr;
        logic [DEF_ADDR_W-1:0]   rt_addr;
        logic [DEF_ADDR_W-1:0]   write_addr;
        logic [DEF_IMM_W-1:0]    immediate;
    } idex_payload_t;

    function automatic int idex_width(input int data_w, input int addr_w,
                                      input int imm_w, input int aluctl_w);
        return aluctl_w + CTRL_W + 2 * data_w + 3 * addr_w + imm_w;
    endfunction

endpackage

// File: rtl/pipe_idex_skid_slot.sv
// Payload + valid register with load/clear; clear wins so a flush can never be overridden.
// Payload holds its value when cleared and resets to zero.
module skid_slot #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic         valid_o
);

    logic [W-1:0] r_q;
    logic         r_valid;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_q     <= '0;
            r_valid <= 1'b0;
        end else if (clear_i) begin
            r_valid <= 1'b0;
        end else if (load_i) begin
            r_q     <= d_i;
            r_valid <= 1'b1;
        end
    end

    assign q_o     = r_q;
    assign valid_o = r_valid;

endmodule

// File: rtl/pipe_idex_skid.sv
// ID/EX stage register with a two-entry skid buffer (main drives EX, skid absorbs one
// beat of back-pressure) and synchronous flush; invalid slots present as bubbles.
module pipe_idex_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int IMM_W    = 5,
    parameter int ALUCTL_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [ALUCTL_W-1:0] alucontrol_i,
    input  logic [CTRL_W-1:0]   ctrl_i,
    input  logic [DATA_W-1:0]   rs_data_i,
    input  logic [DATA_W-1:0]   rt_data_i,
    input  logic [ADDR_W-1:0]   rs_addr_i,
    input  logic [ADDR_W-1:0]   rt_addr_i,
    input  logic [ADDR_W-1:0]   write_addr_i,
    input  logic [IMM_W-1:0]    immediate_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [ALUCTL_W-1:0] alucontrol_o,
    output logic [CTRL_W-1:0]   ctrl_o,
    output logic [DATA_W-1:0]   rs_data_o,
    output logic [DATA_W-1:0]   rt_data_o,
    output logic [ADDR_W-1:0]   rs_addr_o,
    output logic [ADDR_W-1:0]   rt_addr_o,
    output logic [ADDR_W-1:0]   write_addr_o,
    output logic [IMM_W-1:0]    immediate_o
);

    typedef struct packed {
        logic [ALUCTL_W-1:0] alucontrol;
        logic [CTRL_W-1:0]   ctrl;
        logic [DATA_W-1:0]   rs_data;
        logic [DATA_W-1:0]   rt_data;
        logic [ADDR_W-1:0]   rs_addr;
        logic [ADDR_W-1:0]   rt_addr;
        logic [ADDR_W-1:0]   write_addr;
        logic [IMM_W-1:0]    immediate;
    } pl_t;

    localparam int PL_W = idex_width(DATA_W, ADDR_W, IMM_W, ALUCTL_W);

    pl_t  w_in_pl;
    pl_t  w_main_d;
    pl_t  w_main_pl;
    pl_t  w_skid_pl;
    logic w_main_valid;
    logic w_skid_valid;
    logic w_accept;
    logic w_consume;
    logic w_main_take;
    logic w_main_load;
    logic w_main_clear;
    logic w_skid_load;
    logic w_skid_clear;
    logic w_skid_valid_nxt;
    logic r_in_ready;

    assign w_in_pl = '{alucontrol: alucontrol_i, ctrl: ctrl_i, rs_data: rs_data_i,
                       rt_data: rt_data_i, rs_addr: rs_addr_i, rt_addr: rt_addr_i,
                       write_addr: write_addr_i, immediate: immediate_i};

    // Flush has priority, so a same-cycle accept is simply never taken.
    assign w_accept    = in_valid_i & r_in_ready & ~flush_i;
    assign w_consume   = w_main_valid & out_ready_i;
    assign w_main_take = ~w_main_valid | w_consume;

    always_comb begin
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        w_main_d     = w_in_pl;
        if (flush_i) begin
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else if (w_main_take) begin
            if (w_skid_valid) begin
                w_main_load = 1'b1;
                w_main_d    = w_skid_pl;
                w_skid_load = w_accept;
                w_skid_clear = ~w_accept;
            end else if (w_accept) begin
                w_main_load = 1'b1;
            end else begin
                w_main_clear = 1'b1;
            end
        end else begin
            w_skid_load = w_accept;
        end
    end

    always_comb begin
        w_skid_valid_nxt = w_skid_valid;
        if (w_skid_clear)
            w_skid_valid_nxt = 1'b0;
        else if (w_skid_load)
            w_skid_valid_nxt = 1'b1;
    end

    // Registered ready mirrors the next skid state, so out_ready_i never reaches in_ready_o.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_in_ready <= 1'b1;
        else
            r_in_ready <= ~w_skid_valid_nxt;
    end

    skid_slot #(.W(PL_W)) u_main (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (w_main_load),
        .clear_i (w_main_clear),
        .d_i     (w_main_d),
        .q_o     (w_main_pl),
        .valid_o (w_main_valid)
    );

    skid_slot #(.W(PL_W)) u_skid (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (w_skid_load),
        .clear_i (w_skid_clear),
        .d_i     (w_in_pl),
        .q_o     (w_skid_pl),
        .valid_o (w_skid_valid)
    );

    assign in_ready_o   = r_in_ready;
    assign out_valid_o  = w_main_valid;
    assign alucontrol_o = w_main_valid ? w_main_pl.alucontrol : '0;
    assign ctrl_o       = w_main_valid ? w_main_pl.ctrl : '0;
    assign rs_data_o    = w_main_pl.rs_data;
    assign rt_data_o    = w_main_pl.rt_data;
    assign rs_addr_o    = w_main_pl.rs_addr;
    assign rt_addr_o    = w_main_pl.rt_addr;
    assign write_addr_o = w_main_pl.write_addr;
    assign immediate_o  = w_main_pl.immediate;

endmodule

// File: tb/tb_pipe_idex_skid.sv
// Scoreboard bench for pipe_idex_skid: accepted payloads are queued and compared in order
// when EX consumes them, alongside direct checks of reset, stall, flush and bubble behaviour.
module tb_pipe_idex_skid;

    localparam int PLW = 39;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [3:0] alucontrol_i = '0;
    logic [4:0] ctrl_i = '0;
    logic [7:0] rs_data_i = '0;
    logic [7:0] rt_data_i = '0;
    logic [2:0] rs_addr_i = '0;
    logic [2:0] rt_addr_i = '0;
    logic [2:0] write_addr_i = '0;
    logic [4:0] immediate_i = '0;
    logic       out_valid_o;
    logic       out_ready_i = 1'b0;
    logic [3:0] alucontrol_o;
    logic [4:0] ctrl_o;
    logic [7:0] rs_data_o;
    logic [7:0] rt_data_o;
    logic [2:0] rs_addr_o;
    logic [2:0] rt_addr_o;
    logic [2:0] write_addr_o;
    logic [4:0] immediate_o;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    logic [PLW-1:0] sb_q[$];

    pipe_idex_skid dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .alucontrol_i(alucontrol_i), .ctrl_i(ctrl_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
        .write_addr_i(write_addr_i), .immediate_i(immediate_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .alucontrol_o(alucontrol_o), .ctrl_o(ctrl_o),
        .rs_data_o(rs_data_o), .rt_data_o(rt_data_o),
        .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o),
        .write_addr_o(write_addr_o), .immediate_o(immediate_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [PLW-1:0] in_pl();
        return {alucontrol_i, ctrl_i, rs_data_i, rt_data_i, rs_addr_i, rt_addr_i,
                write_addr_i, immediate_i};
    endfunction

    function automatic logic [PLW-1:0] out_pl();
        return {alucontrol_o, ctrl_o, rs_data_o, rt_data_o, rs_addr_o, rt_addr_o,
                write_addr_o, immediate_o};
    endfunction

    task automatic rand_payload();
        alucontrol_i = 4'($urandom);
        ctrl_i       = 5'($urandom);
        rs_data_i    = 8'($urandom);
        rt_data_i    = 8'($urandom);
        rs_addr_i    = 3'($urandom);
        rt_addr_i    = 3'($urandom);
        write_addr_i = 3'($urandom);
        immediate_i  = 5'($urandom);
    endtask

    // Settle, record the handshakes that the coming edge will perform, then advance past it.
    task automatic cyc();
        #1;
        if (out_valid_o && out_ready_i) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_output", 64'(out_pl()), 64'(0));
            end else begin
                chk("sb_payload", 64'(out_pl()), 64'(sb_q.pop_front()));
                pops++;
            end
        end
        if (flush_i)
            sb_q.delete();
        else if (in_valid_i && in_ready_o)
            sb_q.push_back(in_pl());
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset held with a valid input present.
        in_valid_i = 1'b1;
        rand_payload();
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_out_valid", 64'(out_valid_o), 64'(0));
        chk("rst_ctrl", 64'(ctrl_o), 64'(0));
        chk("rst_in_ready", 64'(in_ready_o), 64'(1));
        chk("rst_payload", 64'(out_pl()), 64'(0));
        rst_n_i = 1'b1;

        rand_payload();
        rs_data_i = 8'hA5;
        out_ready_i = 1'b0;
        cyc();
        chk("first_valid", 64'(out_valid_o), 64'(1));
        chk("first_rs_data", 64'(rs_data_o), 64'hA5);
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        cyc();

        // Streaming at full rate.
        for (int i = 0; i < 8; i++) begin
            in_valid_i = 1'b1;
            rand_payload();
            write_addr_i = 3'(i);
            cyc();
            chk("stream_wa", 64'(write_addr_o), 64'(i));
            chk("stream_valid", 64'(out_valid_o), 64'(1));
            chk("stream_ready", 64'(in_ready_o), 64'(1));
        end
        in_valid_i = 1'b0;
        cyc();
        chk("stream_drained", 64'(out_valid_o), 64'(0));

        // Back-pressure: A in main, B into skid, C held off.
        pops = 0;
        out_ready_i = 1'b0;
        in_valid_i = 1'b1;
        rand_payload(); write_addr_i = 3'd1;
        cyc();
        chk("bp_a_ready", 64'(in_ready_o), 64'(1));
        rand_payload(); write_addr_i = 3'd2;
        cyc();
        chk("bp_b_stall", 64'(in_ready_o), 64'(0));
        rand_payload(); write_addr_i = 3'd3;
        cyc();
        chk("bp_hold_a", 64'(write_addr_o), 64'(1));
        chk("bp_stall2", 64'(in_ready_o), 64'(0));
        out_ready_i = 1'b1;
        cyc();
        chk("bp_main_b", 64'(write_addr_o), 64'(2));
        chk("bp_ready_back", 64'(in_ready_o), 64'(1));
        cyc();
        chk("bp_main_c", 64'(write_addr_o), 64'(3));
        in_valid_i = 1'b0;
        cyc();
        chk("bp_pops", 64'(pops), 64'(3));
        chk("bp_queue_empty", 64'(sb_q.size()), 64'(0));

        // Flush with both slots full; D offered in the flush cycle must vanish.
        out_ready_i = 1'b0;
        in_valid_i = 1'b1;
        rand_payload(); cyc();
        rand_payload(); cyc();
        chk("fl_full", 64'(in_ready_o), 64'(0));
        rand_payload(); ctrl_i = 5'b11111; alucontrol_i = 4'hF;
        flush_i = 1'b1;
        in_ready_force_check: begin end
        cyc();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        chk("fl_out_valid", 64'(out_valid_o), 64'(0));
        chk("fl_ctrl", 64'(ctrl_o), 64'(0));
        chk("fl_aluctl", 64'(alucontrol_o), 64'(0));
        chk("fl_in_ready", 64'(in_ready_o), 64'(1));
        out_ready_i = 1'b1;
        repeat (3) cyc();
        chk("fl_no_d", 64'(out_valid_o), 64'(0));

        // Bubble gating after consuming an all-ones control word.
        in_valid_i = 1'b1;
        rand_payload(); ctrl_i = 5'b11111;
        cyc();
        chk("bub_ctrl_live", 64'(ctrl_o), 64'(5'b11111));
        in_valid_i = 1'b0;
        cyc();
        chk("bub_valid", 64'(out_valid_o), 64'(0));
        chk("bub_ctrl", 64'(ctrl_o), 64'(0));

        // Asynchronous reset pulse between edges with both slots full.
        out_ready_i = 1'b0;
        in_valid_i = 1'b1;
        rand_payload(); ctrl_i = 5'b10101; cyc();
        rand_payload(); cyc();
        in_valid_i = 1'b0;
        chk("ar_full", 64'(in_ready_o), 64'(0));
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid_o), 64'(0));
        chk("ar_ctrl", 64'(ctrl_o), 64'(0));
        chk("ar_in_ready", 64'(in_ready_o), 64'(1));
        chk("ar_payload", 64'(out_pl()), 64'(0));
        sb_q.delete();
        #1;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;
        cyc();
        chk("ar_stays_empty", 64'(out_valid_o), 64'(0));
        chk("end_queue_empty", 64'(sb_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
